// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_DASH  = 8'h2D;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO | {4'h0, d};
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Single BCD digit pre-shift adjust: values 5..9 become 8..12 so the shift carries correctly.
module bcd_add3_cell (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional ASCII character output enabled by defining BIN2BCD_ASCII_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_ASCII_EN
  ,
  output logic [DIGITS*8-1:0]   ascii
`endif
);

  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned SW = BW + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [BW-1:0]   adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3_cell u_cell (
      .d_i (sr_q[WIDTH + 4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {{BW{1'b0}}, bin};
          cnt_d   = CW'(WIDTH);
          acc_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Adjusted digits and untouched binary field shift left together; the top bit is the 10^DIGITS carry.
        sr_d  = {adj[BW-2:0], sr_q[WIDTH-1:0], 1'b0};
        acc_d = acc_q | adj[BW-1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = sr_q[SW-1:WIDTH];
        ovf_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;

`ifdef BIN2BCD_ASCII_EN
  logic [DIGITS*8-1:0] ascii_q, ascii_d, ascii_nxt;
  logic                lead;
  logic [3:0]          dig;

  // Scan from the most significant digit; blanking stops at the first non-zero digit or at digit 0.
  always_comb begin
    ascii_nxt = '0;
    lead      = 1'b1;
    dig       = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      dig = sr_q[WIDTH + 4*(DIGITS-1-k) +: 4];
      if (dig != 4'd0 || k == DIGITS - 1) lead = 1'b0;
      ascii_nxt[8*(DIGITS-1-k) +: 8] = acc_q ? CH_DASH : (lead ? CH_SPACE : digit_char(dig));
    end
  end

  always_comb begin
    ascii_d = ascii_q;
    if (state_q == S_DONE) ascii_d = ascii_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ascii_q <= {DIGITS{CH_SPACE}};
    else        ascii_q <= ascii_d;
  end

  assign ascii = ascii_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (DIGITS=3 and DIGITS=2 instances).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start3, start2;
  logic [7:0]  bin3, bin2;
  logic        ready3, ready2, done3, done2, ovf3, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_ASCII_EN
  logic [23:0] ascii3;
  logic [15:0] ascii2;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start3),
    .bin   (bin3),
    .ready (ready3),
    .done  (done3),
    .bcd   (bcd3),
    .ovf   (ovf3)
`ifdef BIN2BCD_ASCII_EN
    ,
    .ascii (ascii3)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .bin   (bin2),
    .ready (ready2),
    .done  (done2),
    .bcd   (bcd2),
    .ovf   (ovf2)
`ifdef BIN2BCD_ASCII_EN
    ,
    .ascii (ascii2)
`endif
  );

  // Returns the number of negedges until done is seen, or -1 after 30 cycles.
  task automatic wait_done3(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done3) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done2(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done2) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic pulse3(input logic [7:0] v);
    @(negedge clk);
    bin3   = v;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic pulse2(input logic [7:0] v);
    @(negedge clk);
    bin2   = v;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
    #1;
    checks++; if (ready3 !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready3); else passed++;
    checks++; if (done3 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done3); else passed++;
    checks++; if (bcd3 !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", bcd3); else passed++;
    checks++; if (ovf3 !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf3); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii3 !== 24'h202020) $display("FAIL reset_ascii: got %h expected 202020", ascii3); else passed++;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max;
    int c;
    pulse3(8'd255);
    checks++; if (ready3 !== 1'b0) $display("FAIL max_ready_drop: got %b expected 0", ready3); else passed++;
    wait_done3(c);
    checks++; if (c !== 9) $display("FAIL max_latency: got %0d expected 9", c); else passed++;
    checks++; if (bcd3 !== 12'h255) $display("FAIL max_bcd: got %h expected 255", bcd3); else passed++;
    checks++; if (ovf3 !== 1'b0) $display("FAIL max_ovf: got %b expected 0", ovf3); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii3 !== 24'h323535) $display("FAIL max_ascii: got %h expected 323535", ascii3); else passed++;
`endif
    checks++; if (ready3 !== 1'b1) $display("FAIL max_ready_back: got %b expected 1", ready3); else passed++;
    @(negedge clk);
    checks++; if (done3 !== 1'b0) $display("FAIL max_done_pulse: got %b expected 0", done3); else passed++;
    checks++; if (bcd3 !== 12'h255) $display("FAIL max_bcd_hold: got %h expected 255", bcd3); else passed++;
  endtask

  task automatic test_zero;
    int c;
    pulse3(8'd0);
    wait_done3(c);
    checks++; if (c !== 9) $display("FAIL zero_latency: got %0d expected 9", c); else passed++;
    checks++; if (bcd3 !== 12'h000) $display("FAIL zero_bcd: got %h expected 000", bcd3); else passed++;
    checks++; if (ovf3 !== 1'b0) $display("FAIL zero_ovf: got %b expected 0", ovf3); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii3 !== 24'h202030) $display("FAIL zero_ascii: got %h expected 202030", ascii3); else passed++;
`endif
  endtask

  task automatic test_back_to_back;
    int c;
    @(negedge clk);
    bin3   = 8'd7;
    start3 = 1'b1;
    wait_done3(c);
    checks++; if (bcd3 !== 12'h007) $display("FAIL b2b_first_bcd: got %h expected 007", bcd3); else passed++;
    wait_done3(c);
    checks++; if (c !== 10) $display("FAIL b2b_interval: got %0d expected 10", c); else passed++;
    checks++; if (bcd3 !== 12'h007) $display("FAIL b2b_second_bcd: got %h expected 007", bcd3); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii3 !== 24'h202037) $display("FAIL b2b_ascii: got %h expected 202037", ascii3); else passed++;
`endif
    start3 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int c;
    int extra;
    pulse3(8'd123);
    @(negedge clk);
    bin3   = 8'd99;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_done3(c);
    checks++; if (c !== 7) $display("FAIL ignore_latency: got %0d expected 7", c); else passed++;
    checks++; if (bcd3 !== 12'h123) $display("FAIL ignore_bcd: got %h expected 123", bcd3); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii3 !== 24'h313233) $display("FAIL ignore_ascii: got %h expected 313233", ascii3); else passed++;
`endif
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done3) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL ignore_extra_done: got %0d expected 0", extra); else passed++;
  endtask

  task automatic test_overflow;
    int c;
    pulse2(8'd200);
    wait_done2(c);
    checks++; if (c !== 9) $display("FAIL ovf200_latency: got %0d expected 9", c); else passed++;
    checks++; if (bcd2 !== 8'h00) $display("FAIL ovf200_bcd: got %h expected 00", bcd2); else passed++;
    checks++; if (ovf2 !== 1'b1) $display("FAIL ovf200_ovf: got %b expected 1", ovf2); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii2 !== 16'h2D2D) $display("FAIL ovf200_ascii: got %h expected 2d2d", ascii2); else passed++;
`endif
    pulse2(8'd99);
    wait_done2(c);
    checks++; if (bcd2 !== 8'h99) $display("FAIL ovf99_bcd: got %h expected 99", bcd2); else passed++;
    checks++; if (ovf2 !== 1'b0) $display("FAIL ovf99_ovf: got %b expected 0", ovf2); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii2 !== 16'h3939) $display("FAIL ovf99_ascii: got %h expected 3939", ascii2); else passed++;
`endif
    pulse2(8'd255);
    wait_done2(c);
    checks++; if (bcd2 !== 8'h55) $display("FAIL ovf255_bcd: got %h expected 55", bcd2); else passed++;
    checks++; if (ovf2 !== 1'b1) $display("FAIL ovf255_ovf: got %b expected 1", ovf2); else passed++;
  endtask

  task automatic test_reset_abort;
    int extra;
    pulse3(8'd200);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready3); else passed++;
    checks++; if (bcd3 !== 12'h000) $display("FAIL abort_bcd: got %h expected 000", bcd3); else passed++;
    checks++; if (done3 !== 1'b0) $display("FAIL abort_done: got %b expected 0", done3); else passed++;
    checks++; if (ovf2 !== 1'b0) $display("FAIL abort_ovf2: got %b expected 0", ovf2); else passed++;
`ifdef BIN2BCD_ASCII_EN
    checks++; if (ascii2 !== 16'h2020) $display("FAIL abort_ascii2: got %h expected 2020", ascii2); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done3) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL abort_no_done: got %0d expected 0", extra); else passed++;
  endtask

  initial begin
    test_reset;
    test_max;
    test_zero;
    test_back_to_back;
    test_ignore_start;
    test_overflow;
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
